// File: rtl/riscv_biu_ahb.sv
// riscv_biu_ahb
// Converts the single arbitrated BIU request stream into AMBA3 AHB-Lite master
// transfers. Address and data phases are pipelined. Burst addresses (INCRn and
// WRAPn) are generated locally from the latched start address, size and type.
//
// Optional feature macro: BIU_RDATA_REG_EN
//   defined   : biu_q_o, biu_ack_o, biu_err_o, biu_adro_o registered (+1 cycle)
//   undefined : those outputs follow HRDATA/HREADY/HRESP combinationally
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   biu_req_i             access request from the BIU port mux
//   biu_req_ack_o         request taken (first address phase loads at this edge)
//   biu_d_ack_o           write data of current beat sampled; present next beat
//   biu_adri_i            access start address
//   biu_adro_o            address of the beat being acknowledged
//   biu_size_i            HSIZE encoding
//   biu_type_i            HBURST encoding
//   biu_lock_i            locked access
//   biu_prot_i            protection
//   biu_we_i              write enable
//   biu_d_i / biu_q_o     write / read data
//   biu_ack_o, biu_err_o  per-beat completion / error
//   H*                    AHB-Lite master interface
module riscv_biu_ahb #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            biu_req_i,
    output logic            biu_req_ack_o,
    output logic            biu_d_ack_o,
    input  logic [PLEN-1:0] biu_adri_i,
    output logic [PLEN-1:0] biu_adro_o,
    input  logic [2:0]      biu_size_i,
    input  logic [2:0]      biu_type_i,
    input  logic            biu_lock_i,
    input  logic [2:0]      biu_prot_i,
    input  logic            biu_we_i,
    input  logic [XLEN-1:0] biu_d_i,
    output logic [XLEN-1:0] biu_q_o,
    output logic            biu_ack_o,
    output logic            biu_err_o,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    // Remaining beats after the first, from the HBURST encoding
    function automatic logic [CNT_W-1:0] beats_m1(input logic [2:0] burst);
        logic [CNT_W-1:0] n;
        case (burst)
            3'd2, 3'd3: n = CNT_W'(3);
            3'd4, 3'd5: n = CNT_W'(7);
            3'd6, 3'd7: n = CNT_W'(15);
            default:    n = CNT_W'(0);
        endcase
        return n;
    endfunction

    function automatic logic is_wrap(input logic [2:0] burst);
        return (burst == 3'd2) || (burst == 3'd4) || (burst == 3'd6);
    endfunction

    // Address-phase state
    htrans_t          tr_q;
    logic [PLEN-1:0]  haddr_q;
    logic [2:0]       size_q;
    logic [2:0]       burst_q;
    logic [2:0]       prot_q;
    logic             we_q;
    logic             lock_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  hwdata_q;
    logic             live_q;

    // Data-phase state
    logic             dp_valid_q;
    logic             dp_we_q;
    logic [PLEN-1:0]  dp_addr_q;

    logic             addr_active_c;
    logic             err_c;
    logic             accept_c;
    logic             next_beat_c;
    logic             d_ack_c;
    logic [PLEN-1:0]  incr_c;
    logic [PLEN-1:0]  sum_c;
    logic [PLEN-1:0]  wrap_blk_c;
    logic [PLEN-1:0]  wrap_mask_c;
    logic [PLEN-1:0]  next_addr_c;
    logic             rsp_ack_c;
    logic             rsp_err_c;
    logic [XLEN-1:0]  rsp_q_c;

    // Handshake decode; any data phase with HRESP=ERROR cancels the burst
    always_comb begin
        addr_active_c = (tr_q == HTRANS_NONSEQ) || (tr_q == HTRANS_SEQ);
        err_c         = dp_valid_q & HRESP;
        accept_c      = live_q & HREADY & biu_req_i & ~err_c &
                        (~addr_active_c | (cnt_q == CNT_W'(0)));
        next_beat_c   = addr_active_c & HREADY & ~err_c & (cnt_q != CNT_W'(0));
        d_ack_c       = addr_active_c & we_q & HREADY & ~err_c;
    end

    // Next burst address: WRAPn keeps bits above the n<<size block boundary
    always_comb begin
        incr_c      = PLEN'(1) << size_q;
        sum_c       = haddr_q + incr_c;
        wrap_blk_c  = (PLEN'(beats_m1(burst_q)) + PLEN'(1)) << size_q;
        wrap_mask_c = wrap_blk_c - PLEN'(1);
        next_addr_c = is_wrap(burst_q) ? ((haddr_q & ~wrap_mask_c) | (sum_c & wrap_mask_c))
                                       : sum_c;
    end

    // Address-phase FSM (state is the registered HTRANS) and data-phase pipe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tr_q       <= HTRANS_IDLE;
            haddr_q    <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            prot_q     <= '0;
            we_q       <= 1'b0;
            lock_q     <= 1'b0;
            cnt_q      <= '0;
            hwdata_q   <= '0;
            live_q     <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_we_q    <= 1'b0;
            dp_addr_q  <= '0;
        end else begin
            // Holds off new requests until the first clock after reset release
            live_q <= 1'b1;

            if (err_c) begin
                tr_q   <= HTRANS_IDLE;
                cnt_q  <= '0;
                lock_q <= 1'b0;
            end else if (HREADY) begin
                if (accept_c) begin
                    tr_q    <= HTRANS_NONSEQ;
                    haddr_q <= biu_adri_i;
                    size_q  <= biu_size_i;
                    burst_q <= biu_type_i;
                    prot_q  <= biu_prot_i;
                    we_q    <= biu_we_i;
                    lock_q  <= biu_lock_i;
                    cnt_q   <= beats_m1(biu_type_i);
                end else if (next_beat_c) begin
                    tr_q    <= HTRANS_SEQ;
                    haddr_q <= next_addr_c;
                    cnt_q   <= cnt_q - CNT_W'(1);
                end else begin
                    tr_q    <= HTRANS_IDLE;
                    lock_q  <= 1'b0;
                end
            end

            if (HREADY) begin
                dp_valid_q <= addr_active_c & ~err_c;
                if (addr_active_c && !err_c) begin
                    dp_we_q   <= we_q;
                    dp_addr_q <= haddr_q;
                end
            end

            if (d_ack_c) begin
                hwdata_q <= biu_d_i;
            end
        end
    end

    // Response decode for the beat in its data phase
    always_comb begin
        rsp_ack_c = dp_valid_q & HREADY & ~HRESP;
        rsp_err_c = dp_valid_q & HREADY & HRESP;
        rsp_q_c   = (dp_valid_q && !dp_we_q) ? HRDATA : '0;
    end

`ifdef BIU_RDATA_REG_EN
    logic             rsp_ack_q;
    logic             rsp_err_q;
    logic [XLEN-1:0]  rsp_q_q;
    logic [PLEN-1:0]  rsp_adr_q;

    // Response retimed by one cycle toward the core
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_ack_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_q_q   <= '0;
            rsp_adr_q <= '0;
        end else begin
            rsp_ack_q <= rsp_ack_c;
            rsp_err_q <= rsp_err_c;
            rsp_q_q   <= rsp_q_c;
            rsp_adr_q <= dp_addr_q;
        end
    end

    assign biu_ack_o  = rsp_ack_q;
    assign biu_err_o  = rsp_err_q;
    assign biu_q_o    = rsp_q_q;
    assign biu_adro_o = rsp_adr_q;
`else
    assign biu_ack_o  = rsp_ack_c;
    assign biu_err_o  = rsp_err_c;
    assign biu_q_o    = rsp_q_c;
    assign biu_adro_o = dp_addr_q;
`endif

    assign biu_req_ack_o = accept_c;
    assign biu_d_ack_o   = d_ack_c;

    // First error cycle drops the pending address phase on the bus at once
    assign HTRANS    = err_c ? HTRANS_IDLE : tr_q;
    assign HSEL      = ~err_c & (tr_q != HTRANS_IDLE);
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = we_q;
    assign HSIZE     = size_q;
    assign HBURST    = burst_q;
    assign HPROT     = {1'b0, prot_q};
    assign HMASTLOCK = lock_q;

endmodule

// File: tb/tb_riscv_biu_ahb.sv
// Directed bench for riscv_biu_ahb (default build, combinational response path).
module tb_riscv_biu_ahb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        biu_req_i;
    logic        biu_req_ack_o;
    logic        biu_d_ack_o;
    logic [63:0] biu_adri_i;
    logic [63:0] biu_adro_o;
    logic [2:0]  biu_size_i;
    logic [2:0]  biu_type_i;
    logic        biu_lock_i;
    logic [2:0]  biu_prot_i;
    logic        biu_we_i;
    logic [63:0] biu_d_i;
    logic [63:0] biu_q_o;
    logic        biu_ack_o;
    logic        biu_err_o;
    logic        HSEL;
    logic [63:0] HADDR;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HRESP;

    riscv_biu_ahb dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .biu_req_i(biu_req_i), .biu_req_ack_o(biu_req_ack_o), .biu_d_ack_o(biu_d_ack_o),
        .biu_adri_i(biu_adri_i), .biu_adro_o(biu_adro_o), .biu_size_i(biu_size_i),
        .biu_type_i(biu_type_i), .biu_lock_i(biu_lock_i), .biu_prot_i(biu_prot_i),
        .biu_we_i(biu_we_i), .biu_d_i(biu_d_i), .biu_q_o(biu_q_o),
        .biu_ack_o(biu_ack_o), .biu_err_o(biu_err_o),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        req;
        logic [63:0] adri;
        logic [2:0]  size, btype;
        logic        we, lock;
        logic [63:0] d, rdata;
        logic [1:0]  e_trans;
        logic [63:0] e_addr, e_wdata;
        logic        e_write, e_lock, e_rack, e_dack, e_ack;
        logic [63:0] e_q, e_adro;
    } vec_t;

    localparam int NV = 16;
    localparam logic [63:0] RD = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] A1 = 64'h1111_0000_0000_0001;
    localparam logic [63:0] A2 = 64'h2222_0000_0000_0002;
    localparam logic [63:0] A3 = 64'h3333_0000_0000_0003;
    localparam logic [63:0] A4 = 64'h4444_0000_0000_0004;
    localparam logic [63:0] D1 = 64'h0BAD_F00D_5A5A_A5A5;
    localparam logic [63:0] R1 = 64'h7777_8888_9999_AAAA;

    vec_t tbl [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] wdat(input int k);
        return 64'hCAFE_0000_0000_0000 | 64'(k);
    endfunction

    task automatic idle_inputs();
        biu_req_i = 1'b0; biu_adri_i = '0; biu_size_i = '0; biu_type_i = '0;
        biu_lock_i = 1'b0; biu_prot_i = '0; biu_we_i = 1'b0; biu_d_i = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    endtask

    initial begin
        int dcnt, acnt, nbeat, stall, seen_stall, stall_bad, addr_bad, data_bad, got_ack;
        logic [63:0] last_adro;

        //                req adri      sz    ty    we    lk    d    rdata | trans addr      wdata wr    lk    rack  dack  ack   q    adro
        tbl[0]  = '{1'b1, 64'h1000, 3'd3, 3'd0, 1'b0, 1'b0, '0, '0,   2'd0, 64'h0,    '0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0,  64'h0};
        tbl[1]  = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, '0,   2'd2, 64'h1000, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0,  64'h0};
        tbl[2]  = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, RD,   2'd0, 64'h1000, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RD,  64'h1000};
        tbl[3]  = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, RD,   2'd0, 64'h1000, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0,  64'h1000};
        tbl[4]  = '{1'b1, 64'h1018, 3'd3, 3'd2, 1'b0, 1'b1, '0, '0,   2'd0, 64'h1000, '0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0,  64'h1000};
        tbl[5]  = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, '0,   2'd2, 64'h1018, '0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,  64'h1000};
        tbl[6]  = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, A1,   2'd3, 64'h1000, '0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, A1,  64'h1018};
        tbl[7]  = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, A2,   2'd3, 64'h1008, '0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, A2,  64'h1000};
        tbl[8]  = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, A3,   2'd3, 64'h1010, '0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, A3,  64'h1008};
        tbl[9]  = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, A4,   2'd0, 64'h1010, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, A4,  64'h1010};
        tbl[10] = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, '0,   2'd0, 64'h1010, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0,  64'h1010};
        tbl[11] = '{1'b1, 64'h2000, 3'd2, 3'd0, 1'b1, 1'b0, D1, '0,   2'd0, 64'h1010, '0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0,  64'h1010};
        tbl[12] = '{1'b1, 64'h2004, 3'd2, 3'd0, 1'b0, 1'b0, D1, '0,   2'd2, 64'h2000, '0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0,  64'h1010};
        tbl[13] = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, R1,   2'd2, 64'h2004, D1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0,  64'h2000};
        tbl[14] = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, R1,   2'd0, 64'h2004, D1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, R1,  64'h2004};
        tbl[15] = '{1'b0, '0,       3'd0, 3'd0, 1'b0, 1'b0, '0, '0,   2'd0, 64'h2004, D1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0,  64'h2004};

        // Reset state, with a request and read data pending on the inputs
        rst_ni = 1'b0;
        idle_inputs();
        biu_req_i = 1'b1; biu_adri_i = 64'h9000; HRDATA = RD;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_htrans",  64'(HTRANS), 64'd0);
        chk("rst_hsel",    64'(HSEL), 64'd0);
        chk("rst_haddr",   HADDR, 64'd0);
        chk("rst_req_ack", 64'(biu_req_ack_o), 64'd0);
        chk("rst_q",       biu_q_o, 64'd0);
        chk("rst_ack_err", 64'({biu_ack_o, biu_err_o, biu_d_ack_o}), 64'd0);
        @(posedge clk_i); #1;
        idle_inputs();
        rst_ni = 1'b1;

        // Single read, WRAP4 locked read, back-to-back write/read
        for (int i = 0; i < NV; i++) begin
            @(posedge clk_i); #1;
            biu_req_i = tbl[i].req; biu_adri_i = tbl[i].adri; biu_size_i = tbl[i].size;
            biu_type_i = tbl[i].btype; biu_we_i = tbl[i].we; biu_lock_i = tbl[i].lock;
            biu_d_i = tbl[i].d; HRDATA = tbl[i].rdata; HREADY = 1'b1; HRESP = 1'b0;
            @(negedge clk_i);
            n_vec++;
            if (HTRANS !== tbl[i].e_trans || HADDR !== tbl[i].e_addr || HWDATA !== tbl[i].e_wdata ||
                HWRITE !== tbl[i].e_write || HMASTLOCK !== tbl[i].e_lock ||
                biu_req_ack_o !== tbl[i].e_rack || biu_d_ack_o !== tbl[i].e_dack ||
                biu_ack_o !== tbl[i].e_ack || biu_err_o !== 1'b0 ||
                biu_q_o !== tbl[i].e_q || biu_adro_o !== tbl[i].e_adro) begin
                n_bad++;
                $display("FAIL row %0d (got/exp): trans=%0d/%0d addr=%h/%h wdata=%h/%h write=%b/%b lock=%b/%b rack=%b/%b dack=%b/%b ack=%b/%b err=%b/0 q=%h/%h adro=%h/%h",
                         i, HTRANS, tbl[i].e_trans, HADDR, tbl[i].e_addr, HWDATA, tbl[i].e_wdata,
                         HWRITE, tbl[i].e_write, HMASTLOCK, tbl[i].e_lock,
                         biu_req_ack_o, tbl[i].e_rack, biu_d_ack_o, tbl[i].e_dack,
                         biu_ack_o, tbl[i].e_ack, biu_err_o, biu_q_o, tbl[i].e_q,
                         biu_adro_o, tbl[i].e_adro);
            end
        end

        // INCR8 write, size 2, two wait states on the beat-3 address phase
        @(posedge clk_i); #1;
        idle_inputs();
        biu_req_i = 1'b1; biu_adri_i = 64'h3000; biu_size_i = 3'd2; biu_type_i = 3'd5;
        biu_we_i = 1'b1; biu_d_i = wdat(0);
        @(negedge clk_i);
        chk("incr8_req_ack", 64'(biu_req_ack_o), 64'd1);
        dcnt = 0; acnt = 0; nbeat = 0; stall = 0; seen_stall = 0;
        stall_bad = 0; addr_bad = 0; data_bad = 0; last_adro = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i); #1;
            biu_req_i = 1'b0;
            biu_d_i = wdat(dcnt);
            if (seen_stall == 0 && HADDR == 64'h300C && HTRANS == 2'd3) begin
                stall = 2; seen_stall = 1;
            end
            HREADY = (stall == 0);
            if (stall > 0) begin
                if (HADDR !== 64'h300C || HTRANS !== 2'd3 || HWDATA !== wdat(2)) stall_bad++;
                stall--;
            end
            @(negedge clk_i);
            if (HREADY && HTRANS != 2'd0) begin
                if (HADDR !== 64'h3000 + 64'(4 * nbeat)) addr_bad++;
                nbeat++;
            end
            if (biu_d_ack_o) dcnt++;
            if (biu_ack_o) begin
                if (HWDATA !== wdat(acnt)) data_bad++;
                acnt++;
                last_adro = biu_adro_o;
            end
            if (acnt == 8) break;
        end
        chk("incr8_stall_seen", 64'(seen_stall), 64'd1);
        chk("incr8_stall_hold", 64'(stall_bad), 64'd0);
        chk("incr8_addr_seq",   64'(addr_bad), 64'd0);
        chk("incr8_beats",      64'(nbeat), 64'd8);
        chk("incr8_d_acks",     64'(dcnt), 64'd8);
        chk("incr8_acks",       64'(acnt), 64'd8);
        chk("incr8_wdata",      64'(data_bad), 64'd0);
        chk("incr8_last_adro",  last_adro, 64'h301C);

        // INCR4 read, ERROR response on beat 2
        @(posedge clk_i); #1;
        idle_inputs();
        biu_req_i = 1'b1; biu_adri_i = 64'h4000; biu_size_i = 3'd3; biu_type_i = 3'd3;
        @(negedge clk_i);
        chk("err_req_ack", 64'(biu_req_ack_o), 64'd1);
        @(posedge clk_i); #1;
        biu_req_i = 1'b0;
        @(negedge clk_i);
        chk("err_b0_addr", {HADDR[61:0], HTRANS}, {62'h4000, 2'd2});
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("err_b0_ack", {biu_adro_o[62:0], biu_ack_o}, {63'h4000, 1'b1});
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("err_b1_ack", {biu_adro_o[62:0], biu_ack_o}, {63'h4008, 1'b1});
        @(posedge clk_i); #1;
        HREADY = 1'b0; HRESP = 1'b1;
        @(negedge clk_i);
        chk("err_c1_htrans", 64'({HTRANS, HSEL}), 64'd0);
        chk("err_c1_resp",   64'({biu_ack_o, biu_err_o}), 64'd0);
        @(posedge clk_i); #1;
        HREADY = 1'b1; HRESP = 1'b1;
        biu_req_i = 1'b1; biu_adri_i = 64'h5000; biu_type_i = 3'd0;
        @(negedge clk_i);
        chk("err_c2_resp",    64'({biu_ack_o, biu_err_o}), 64'd1);
        chk("err_c2_no_req",  64'(biu_req_ack_o), 64'd0);
        chk("err_c2_htrans",  64'(HTRANS), 64'd0);
        @(posedge clk_i); #1;
        HRESP = 1'b0;
        @(negedge clk_i);
        chk("err_after_resp", 64'({biu_ack_o, biu_err_o, HTRANS}), 64'd0);
        chk("err_after_req",  64'(biu_req_ack_o), 64'd1);
        @(posedge clk_i); #1;
        biu_req_i = 1'b0;
        @(negedge clk_i);
        chk("err_next_addr", {HADDR[61:0], HTRANS}, {62'h5000, 2'd2});
        @(posedge clk_i); #1;
        HRDATA = 64'h5555_6666_0000_1234;
        @(negedge clk_i);
        chk("err_next_q", biu_ack_o ? biu_q_o : 64'hFFFF, 64'h5555_6666_0000_1234);

        // WRAP8 locked read abandoned by asynchronous reset
        @(posedge clk_i); #1;
        idle_inputs();
        biu_req_i = 1'b1; biu_adri_i = 64'h6000; biu_size_i = 3'd3; biu_type_i = 3'd4;
        biu_lock_i = 1'b1; biu_prot_i = 3'd5;
        @(negedge clk_i);
        chk("rw8_req_ack", 64'(biu_req_ack_o), 64'd1);
        @(posedge clk_i); #1;
        biu_req_i = 1'b0;
        @(negedge clk_i);
        chk("rw8_lock", 64'({HTRANS, HMASTLOCK, HPROT}), 64'({2'd2, 1'b1, 4'd5}));
        @(posedge clk_i); #1;
        HRDATA = 64'hABCD_ABCD_ABCD_ABCD;
        #1 rst_ni = 1'b0;
        biu_req_i = 1'b1; biu_adri_i = 64'h8000;
        #1;
        chk("rw8_rst_htrans", 64'({HTRANS, HSEL, HMASTLOCK, HWRITE}), 64'd0);
        chk("rw8_rst_haddr",  HADDR, 64'd0);
        chk("rw8_rst_hwdata", HWDATA, 64'd0);
        chk("rw8_rst_ctrl",   64'({HSIZE, HBURST, HPROT}), 64'd0);
        chk("rw8_rst_resp",   64'({biu_ack_o, biu_err_o, biu_req_ack_o, biu_d_ack_o}), 64'd0);
        chk("rw8_rst_q",      biu_q_o, 64'd0);
        chk("rw8_rst_adro",   biu_adro_o, 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        idle_inputs();
        biu_req_i = 1'b1; biu_adri_i = 64'h7000; biu_size_i = 3'd3;
        rst_ni = 1'b1;
        got_ack = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            if (biu_req_ack_o) begin
                got_ack = 1;
                break;
            end
        end
        chk("post_rst_req_ack", 64'(got_ack), 64'd1);
        @(posedge clk_i); #1;
        biu_req_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_addr", {HADDR[60:0], HTRANS, HSEL}, {61'h7000, 2'd2, 1'b1});
        @(posedge clk_i); #1;
        HRDATA = 64'h0123_4567_89AB_CDEF;
        @(negedge clk_i);
        chk("post_rst_ack", 64'({biu_ack_o, biu_err_o}), 64'd2);
        chk("post_rst_q",   biu_q_o, 64'h0123_4567_89AB_CDEF);
        chk("post_rst_adro", biu_adro_o, 64'h7000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
